// File: rtl/cv32e40x_mul_serial_if.sv
// Handshake and operand bundle between EX and the serial multiplier.
// The master side is EX, and the slave side is the multiplier.
interface cv32e40x_mul_serial_if;
  logic [1:0]  operator_i;
  logic        data_ind_timing_i;
  logic [31:0] op_a_i;
  logic [31:0] op_b_i;
  logic        halt_i;
  logic        valid_i;
  logic        ready_o;
  logic        ready_i;
  logic        valid_o;
  logic [31:0] result_o;

  modport master (
    output operator_i, data_ind_timing_i, op_a_i, op_b_i, halt_i, valid_i, ready_i,
    input  ready_o, valid_o, result_o
  );

  modport slave (
    input  operator_i, data_ind_timing_i, op_a_i, op_b_i, halt_i, valid_i, ready_i,
    output ready_o, valid_o, result_o
  );
endinterface

// File: rtl/cv32e40x_mul_serial.sv
// Radix-2 shift-add multiplier for MUL/MULH/MULHSU/MULHU.
// It multiplies the operand magnitudes over 32 cycles, then sign-corrects the result on the output path.
module cv32e40x_mul_serial (
  input  logic                       clk,
  input  logic                       rst_n,
  cv32e40x_mul_serial_if.slave       bus
);

  localparam int unsigned W  = 32;
  localparam int unsigned PW = 2 * W;
  localparam int unsigned CW = 6;

  localparam logic [1:0] OP_MUL    = 2'b00;
  localparam logic [1:0] OP_MULH   = 2'b01;
  localparam logic [1:0] OP_MULHSU = 2'b10;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    MULT   = 2'd1,
    FINISH = 2'd2
  } state_t;

  state_t          state_q;
  logic [PW-1:0]   p_q;
  logic [W-1:0]    mcand_q;
  logic [CW-1:0]   cnt_q;
  logic            sel_hi_q;
  logic            res_inv_q;

  logic            a_neg;
  logic            b_neg;
  logic [W-1:0]    mcand;
  logic [W-1:0]    mplier;
  logic            res_inv;
  logic            zero_op;
  logic            kill;
  logic [W:0]      sum;
  logic [PW-1:0]   prod;

  // Operand sign decode and magnitudes
  always_comb begin
    a_neg   = ((bus.operator_i == OP_MULH) || (bus.operator_i == OP_MULHSU)) && bus.op_a_i[W-1];
    b_neg   = (bus.operator_i == OP_MULH) && bus.op_b_i[W-1];
    mcand   = a_neg ? (W'(0) - bus.op_a_i) : bus.op_a_i;
    mplier  = b_neg ? (W'(0) - bus.op_b_i) : bus.op_b_i;
    res_inv = (a_neg ^ b_neg) && (bus.operator_i != OP_MUL);
    zero_op = (mcand == W'(0)) || (mplier == W'(0));
  end

  assign kill = !bus.valid_i && !bus.halt_i;
  assign sum  = {1'b0, p_q[PW-1:W]} + (p_q[0] ? {1'b0, mcand_q} : (W+1)'(0));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      p_q       <= PW'(0);
      mcand_q   <= W'(0);
      cnt_q     <= CW'(0);
      sel_hi_q  <= 1'b0;
      res_inv_q <= 1'b0;
    end else if (kill) begin
      state_q <= IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.valid_i) begin
            mcand_q   <= mcand;
            cnt_q     <= CW'(W);
            sel_hi_q  <= (bus.operator_i != OP_MUL);
            res_inv_q <= res_inv;
            // A zero operand skips the iteration unless constant timing is requested
            if (zero_op && !bus.data_ind_timing_i) begin
              p_q     <= PW'(0);
              state_q <= FINISH;
            end else begin
              p_q     <= {W'(0), mplier};
              state_q <= MULT;
            end
          end
        end
        MULT: begin
          p_q   <= {sum, p_q[W-1:1]};
          cnt_q <= cnt_q - CW'(1);
          if (cnt_q == CW'(1)) state_q <= FINISH;
        end
        FINISH: begin
          if (bus.ready_i) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Handshake outputs; kill takes precedence over the state decode
  always_comb begin
    bus.ready_o = 1'b0;
    bus.valid_o = 1'b0;
    if (kill) begin
      bus.ready_o = 1'b1;
    end else if (state_q == FINISH) begin
      bus.valid_o = 1'b1;
      bus.ready_o = bus.ready_i;
    end
  end

  assign prod         = res_inv_q ? (PW'(0) - p_q) : p_q;
  assign bus.result_o = sel_hi_q ? prod[PW-1:W] : prod[W-1:0];

endmodule

// File: tb/tb_cv32e40x_mul_serial.sv
// Directed and random checks of the serial multiplier.
// Expected results come from a 64-bit arithmetic reference model.
module tb_cv32e40x_mul_serial;

  localparam logic [1:0] MUL = 2'b00, MULH = 2'b01, MULHSU = 2'b10, MULHU = 2'b11;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   tests = 0;
  int   fails = 0;

  cv32e40x_mul_serial_if bus();

  cv32e40x_mul_serial dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: sign- or zero-extend the operands, take the 64-bit product, then pick a word
  function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] ea, eb, p;
    ea = (op == MULH || op == MULHSU) ? {{32{a[31]}}, a} : {32'b0, a};
    eb = (op == MULH) ? {{32{b[31]}}, b} : {32'b0, b};
    p  = ea * eb;
    return (op == MUL) ? p[31:0] : p[63:32];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    do begin
      tick();
      lat++;
      #1;
    end while (!bus.valid_o && lat < 60);
  endtask

  // Start an operation in the current cycle, which is cycle 0, and check the latency, result and handshake
  task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic dit, input int exp_lat,
                        input logic [31:0] exp_res);
    int lat;
    bus.operator_i = op; bus.op_a_i = a; bus.op_b_i = b; bus.data_ind_timing_i = dit;
    bus.valid_i = 1'b1; bus.halt_i = 1'b0; bus.ready_i = 1'b1;
    #1;
    chk({tag, "_rdy0"}, 64'(bus.ready_o), 64'd0);
    wait_valid(lat);
    chk({tag, "_lat"}, 64'(lat), 64'(exp_lat));
    chk({tag, "_res"}, 64'(bus.result_o), 64'(exp_res));
    chk({tag, "_rdy"}, 64'(bus.ready_o), 64'd1);
    tick();
    bus.valid_i = 1'b0;
    #1;
    chk({tag, "_vld_drop"}, 64'(bus.valid_o), 64'd0);
  endtask

  initial begin
    int lat;
    logic [31:0] hold;
    bus.operator_i = MUL; bus.op_a_i = '0; bus.op_b_i = '0; bus.data_ind_timing_i = 1'b0;
    bus.halt_i = 1'b0; bus.valid_i = 1'b0; bus.ready_i = 1'b0;

    #12;
    chk("rst_valid", 64'(bus.valid_o), 64'd0);
    chk("rst_result", 64'(bus.result_o), 64'd0);
    rst_n = 1'b1;
    tick();

    run_op("mulhu_ff",  MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 33, 32'hFFFFFFFE);
    run_op("mul_ff",    MUL,    32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 33, 32'h00000001);
    run_op("mulh_min",  MULH,   32'h80000000, 32'h80000000, 1'b0, 33, 32'h40000000);
    run_op("mulh_m1x7", MULH,   32'hFFFFFFFF, 32'h00000007, 1'b0, 33, 32'hFFFFFFFF);
    run_op("mul_m2x3",  MUL,    32'hFFFFFFFE, 32'h00000003, 1'b0, 33, 32'hFFFFFFFA);
    run_op("mulhsu_m1", MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 33, 32'hFFFFFFFF);
    run_op("mulhsu_2",  MULHSU, 32'h00000002, 32'h80000000, 1'b0, 33, 32'h00000001);
    run_op("zero_early", MULH,  32'h00000000, 32'h12345678, 1'b0, 1,  32'h00000000);
    run_op("zero_dit",   MULH,  32'h00000000, 32'h12345678, 1'b1, 33, 32'h00000000);

    // Kill in cycle 10
    bus.operator_i = MULHU; bus.op_a_i = 32'hDEADBEEF; bus.op_b_i = 32'h12345678;
    bus.valid_i = 1'b1; bus.ready_i = 1'b1; bus.halt_i = 1'b0;
    for (int k = 0; k < 10; k++) tick();
    bus.valid_i = 1'b0;
    #1;
    chk("kill_ready", 64'(bus.ready_o), 64'd1);
    chk("kill_valid", 64'(bus.valid_o), 64'd0);
    tick();
    run_op("after_kill", MULHU, 32'h00010000, 32'h00010000, 1'b0, 33, 32'h00000001);

    // Halt in cycle 10 does not kill
    bus.operator_i = MULHU; bus.op_a_i = 32'hDEADBEEF; bus.op_b_i = 32'h12345678;
    bus.data_ind_timing_i = 1'b0; bus.valid_i = 1'b1; bus.ready_i = 1'b1; bus.halt_i = 1'b0;
    for (int k = 0; k < 10; k++) tick();
    bus.valid_i = 1'b0; bus.halt_i = 1'b1;
    #1;
    chk("halt_ready", 64'(bus.ready_o), 64'd0);
    lat = 10;
    do begin tick(); lat++; #1; end while (!bus.valid_o && lat < 60);
    chk("halt_lat", 64'(lat), 64'd33);
    chk("halt_res", 64'(bus.result_o), 64'(model(MULHU, 32'hDEADBEEF, 32'h12345678)));
    tick();
    bus.halt_i = 1'b0;
    #1;
    chk("halt_idle", 64'(bus.valid_o), 64'd0);

    // Backpressure in FINISH
    bus.operator_i = MULH; bus.op_a_i = 32'h87654321; bus.op_b_i = 32'h0FEDCBA9;
    bus.valid_i = 1'b1; bus.ready_i = 1'b0;
    wait_valid(lat);
    chk("bp_lat", 64'(lat), 64'd33);
    hold = model(MULH, 32'h87654321, 32'h0FEDCBA9);
    for (int k = 0; k < 5; k++) begin
      chk("bp_valid", 64'(bus.valid_o), 64'd1);
      chk("bp_res", 64'(bus.result_o), 64'(hold));
      chk("bp_rdy", 64'(bus.ready_o), 64'd0);
      tick();
      #1;
    end
    bus.ready_i = 1'b1;
    #1;
    chk("bp_release", 64'(bus.ready_o), 64'd1);
    tick();
    #1;
    chk("bp_done", 64'(bus.valid_o), 64'd0);
    bus.valid_i = 1'b0;
    tick();

    // Random operations, with some zero operands mixed in
    for (int i = 0; i < 24; i++) begin
      logic [1:0]  op;
      logic [31:0] a, b;
      logic        dit;
      op  = 2'($urandom_range(0, 3));
      a   = $urandom;
      b   = $urandom;
      dit = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 5) == 0) a = '0;
      if ($urandom_range(0, 5) == 0) b = '0;
      if ($urandom_range(0, 4) == 0) a = {1'b1, 31'($urandom_range(0, 3))};
      run_op("rand", op, a, b, dit, ((a == 0 || b == 0) && !dit) ? 1 : 33, model(op, a, b));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/cv32e40x_mul_serial.md
Name: cv32e40x_mul_serial

Overview:
Iterative radix-2 shift-add multiplier that completes the M-extension arithmetic alongside the serial divider in EX.
- Computes the 64-bit product of two 32-bit operands from magnitudes, then sign-corrects it.
- Returns the low word (MUL) or high word (MULH/MULHSU/MULHU).
- Uses the same valid/ready and kill handshake as the divider, so EX can sequence either unit the same way.

Parameters:
None.

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
operator_i  in  2  00 MUL, 01 MULH, 10 MULHSU, 11 MULHU
data_ind_timing_i  in  1  1 disables the zero-operand early-out
op_a_i  in  32  multiplicand (rs1)
op_b_i  in  32  multiplier (rs2)
halt_i  in  1  EX halted; blocks kill
valid_i  in  1  operation present; deassertion kills
ready_o  out  1  operation consumed/killed
ready_i  in  1  downstream accepts result
valid_o  out  1  result valid
result_o  out  32  selected, sign-corrected result word

Behaviour:
- Reset: rst_n, asynchronous, active-low; clock clk. On reset:
  - state=IDLE; all datapath registers = 0; valid_o=0; result_o=0.
  - ready_o follows the combinational rules below.
- Sign decode:
  - a_signed = MULH|MULHSU; b_signed = MULH.
  - a_neg = a_signed & op_a_i[31]; b_neg = b_signed & op_b_i[31].
  - Magnitudes: mcand = a_neg ? -op_a_i : op_a_i; mplier likewise for b, both as 32-bit unsigned (0x80000000 maps to 0x80000000).
  - res_inv = (a_neg ^ b_neg) & (operator != MUL). MUL is treated as unsigned; the low word is sign-agnostic.
- Registers:
  - P[63:0]: P[31:0] is initialised with mplier; P[63:32] is the accumulator.
  - mcand_q[31:0], cnt_q[5:0], sel_hi_q, res_inv_q.
- IDLE (valid_i=1):
  - Load P={32'b0, mplier}, mcand_q, cnt_q=32, sel_hi_q, res_inv_q.
  - If (mcand==0 | mplier==0) & !data_ind_timing_i: P=0, next=FINISH. Otherwise next=MULT.
- MULT, each cycle:
  - sum[32:0] = P[63:32] + (P[0] ? mcand_q : 0).
  - P <= {sum, P[31:1]}; cnt_q <= cnt_q-1.
  - When cnt_q==1: next=FINISH.
  - Exactly 32 MULT cycles; P then holds the unsigned 64-bit product.
- FINISH:
  - valid_o=1.
  - If ready_i: ready_o=1, next=IDLE. Otherwise hold; P and result_o stay stable.
- Output path (combinational from registers):
  - prod = res_inv_q ? -P : P (64-bit two's complement).
  - result_o = sel_hi_q ? prod[63:32] : prod[31:0].
- Latency (accept = cycle 0 in IDLE):
  - Normal: valid_o first in cycle 33.
  - Early-out: valid_o first in cycle 1.
  - ready_o is 0 in IDLE/MULT while valid_i=1.
- Kill: if !valid_i & !halt_i in any state, next=IDLE, ready_o=1, valid_o=0 (overrides the case logic). Partial state is discarded.
- Halt: valid_i=0 with halt_i=1 does not kill; the computation continues.
- No back-to-back overlap: a new operation is accepted only from IDLE.

Test Plan:
1. MULHU 0xFFFFFFFF×0xFFFFFFFF, ready_i=1 -> valid_o only in cycle 33, result_o=0xFFFFFFFE; MUL with the same operands -> 0x00000001.
2. MULH 0x80000000×0x80000000 -> 0x40000000; MULH 0xFFFFFFFF(-1)×0x00000007 -> 0xFFFFFFFF; MUL 0xFFFFFFFE×0x00000003 -> 0xFFFFFFFA.
3. MULHSU 0xFFFFFFFF(-1)×0xFFFFFFFF(unsigned) -> product 0xFFFFFFFF_00000001, result_o=0xFFFFFFFF; MULHSU 0x00000002×0x80000000 -> 0x00000001.
4. MULH 0x00000000×0x12345678:
   - data_ind_timing_i=0 -> valid_o in cycle 1, result_o=0.
   - data_ind_timing_i=1 -> valid_o in cycle 33, result_o=0.
5. Kill: start MULHU, drive valid_i=0 with halt_i=0 in cycle 10 -> ready_o=1 that cycle, IDLE next. Then MULHU 0x00010000×0x00010000 -> 0x00000001. Repeat with halt_i=1 in cycle 10 -> no kill, original result delivered in cycle 33.
6. Backpressure: hold ready_i=0 for 5 cycles in FINISH -> valid_o=1 and result_o constant throughout. Raising ready_i -> ready_o=1 that cycle, valid_o=0 in the next cycle.
